// File: rtl/bar_renderer_if.sv
// Column-write stream from the peak-hold stage and pixel stream to the panel,
// bundled as seen from the renderer (slave) and from its neighbours (master).
interface bar_renderer_if;
  logic       new_frame_i;
  logic       start_i;
  logic [6:0] bar_i;
  logic [6:0] top_i;
  logic       pix_ready_i;
  logic       pix_valid_o;
  logic [1:0] pixel_o;
  logic       line_start_o;
  logic       frame_start_o;

  modport master (
    output new_frame_i, start_i, bar_i, top_i, pix_ready_i,
    input  pix_valid_o, pixel_o, line_start_o, frame_start_o
  );

  modport slave (
    input  new_frame_i, start_i, bar_i, top_i, pix_ready_i,
    output pix_valid_o, pixel_o, line_start_o, frame_start_o
  );
endinterface

// File: rtl/bar_renderer.sv
// Spectrum bar raster renderer: double-buffered column memory, read bank swaps
// only when the last pixel of a frame is accepted, valid/ready pixel output.
//
// state | meaning
// IDLE  | no complete bank yet, pixel stream quiet
// SCAN  | rastering the read bank, top row first, left to right
module bar_renderer #(
  parameter int COLUMNS = 800,
  parameter int ADDR_W  = 10,
  parameter int ROWS    = 128
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bar_renderer_if.slave bus
);

  localparam logic [ADDR_W:0]   W_FULL = (ADDR_W + 1)'(COLUMNS);
  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(COLUMNS - 1);
  localparam logic [6:0]        Y_TOP  = 7'(ROWS - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  logic [13:0]       mem_q [2][COLUMNS];

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic              wb_q, wb_d;
  logic              swap_pend_q, swap_pend_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic              pix_valid_q, pix_valid_d;
  logic [1:0]        pixel_q, pixel_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;

  logic              wr_en, accept, frame_end, swap, load, rd_bank;
  logic [ADDR_W-1:0] nx;
  logic [6:0]        ny;
  logic [13:0]       rd_ent;
  logic [1:0]        pix_new;

  function automatic logic [1:0] pix_of(input logic [13:0] ent, input logic [6:0] row);
    logic [6:0] t;
    logic [6:0] b;
    t = ent[13:7];
    b = ent[6:0];
    if (t != 7'd0 && row == t) return 2'd2;
    if (row < b) return 2'd1;
    return 2'd0;
  endfunction

  assign wr_en     = bus.start_i & ~bus.new_frame_i & (wptr_q < W_FULL);
  assign accept    = pix_valid_q & bus.pix_ready_i;
  assign frame_end = accept & (x_q == X_LAST) & (y_q == 7'd0);
  assign swap      = swap_pend_q & ((state_q == ST_IDLE) | frame_end);

  // The next pixel is fetched on the accept edge itself, so the bank chosen
  // here already reflects a swap happening in this cycle.
  assign rd_bank = swap ? wb_q : ~wb_q;

  always_comb begin
    nx = x_q;
    ny = y_q;
    if (state_q == ST_SCAN && accept) begin
      if (x_q == X_LAST) begin
        nx = '0;
        ny = (y_q == 7'd0) ? Y_TOP : y_q - 7'd1;
      end else begin
        nx = x_q + 1'b1;
      end
    end
  end

  assign rd_ent  = mem_q[rd_bank][nx];
  assign pix_new = pix_of(rd_ent, ny);

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    wb_d          = wb_q;
    swap_pend_d   = swap_pend_q;
    x_d           = nx;
    y_d           = ny;
    pix_valid_d   = pix_valid_q;
    pixel_d       = pixel_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    load          = 1'b0;

    if (bus.new_frame_i) wptr_d = '0;
    else if (wr_en)      wptr_d = wptr_q + 1'b1;

    if (swap) begin
      swap_pend_d = 1'b0;
      wb_d        = ~wb_q;
    end else if (bus.new_frame_i && wptr_q == W_FULL) begin
      swap_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (swap) begin
          state_d = ST_SCAN;
          load    = 1'b1;
        end
      end
      ST_SCAN: load = accept;
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      pix_valid_d   = 1'b1;
      pixel_d       = pix_new;
      line_start_d  = (nx == '0);
      frame_start_d = (nx == '0) && (ny == Y_TOP);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wb_q][wptr_q[ADDR_W-1:0]] <= {bus.top_i, bus.bar_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      wptr_q        <= '0;
      wb_q          <= 1'b0;
      swap_pend_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= Y_TOP;
      pix_valid_q   <= 1'b0;
      pixel_q       <= 2'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      wb_q          <= wb_d;
      swap_pend_q   <= swap_pend_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_valid_q   <= pix_valid_d;
      pixel_q       <= pixel_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pix_valid_o   = pix_valid_q;
  assign bus.pixel_o       = pixel_q;
  assign bus.line_start_o  = line_start_q;
  assign bus.frame_start_o = frame_start_q;

endmodule

// File: tb/tb_bar_renderer.sv
// Scoreboard bench for bar_renderer: completed frames are queued as column
// images; a monitor rasterises them and compares every accepted pixel.
module tb_bar_renderer;

  localparam int COLUMNS = 24;
  localparam int ADDR_W  = 5;
  localparam int ROWS    = 16;
  localparam int FRAME   = COLUMNS * ROWS;

  logic clk = 1'b0;
  logic rst;
  bar_renderer_if bus();

  bar_renderer #(.COLUMNS(COLUMNS), .ADDR_W(ADDR_W), .ROWS(ROWS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [13:0] cur_cols[$];
  logic [13:0] pend[$];
  logic [13:0] img [COLUMNS];
  bit          mon_active = 1'b0;
  bit          stall_q = 1'b0;
  bit          rdy_rand = 1'b0;
  logic [4:0]  held;
  int          mon_x, mon_y, exp_v;
  int          acc_count = 0;
  int          reset_epoch = 0;
  int          seen_epoch = 0;

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference raster rule: marker row beats bar, bar covers rows below height.
  function automatic int ref_pixel(input logic [13:0] ent, input int y);
    int t;
    int b;
    t = int'(ent[13:7]);
    b = int'(ent[6:0]);
    if (t != 0 && y == t) return 2;
    if (y < b) return 1;
    return 0;
  endfunction

  function automatic void load_frame();
    for (int i = 0; i < COLUMNS; i++) img[i] = pend.pop_front();
  endfunction

  // Monitor: samples on the falling edge, a transfer happens on the next rise.
  always @(negedge clk) begin
    if (!rst) begin
      if (seen_epoch != reset_epoch) begin
        seen_epoch = reset_epoch;
        mon_active = 1'b0;
        stall_q    = 1'b0;
      end
      if (stall_q)
        check("stall_hold", int'({bus.pix_valid_o, bus.pixel_o, bus.line_start_o, bus.frame_start_o}),
              int'(held));
      if (bus.pix_valid_o && !mon_active) begin
        if (pend.size() >= COLUMNS) begin
          load_frame();
          mon_active = 1'b1;
          mon_x = 0;
          mon_y = ROWS - 1;
        end else begin
          check("spurious_pixel", int'(bus.pix_valid_o), 0);
        end
      end
      if (bus.pix_valid_o && bus.pix_ready_i && mon_active) begin
        exp_v = ref_pixel(img[mon_x], mon_y) * 4 + ((mon_x == 0) ? 2 : 0) +
                ((mon_x == 0 && mon_y == ROWS - 1) ? 1 : 0);
        check("pixel", int'({bus.pixel_o, bus.line_start_o, bus.frame_start_o}), exp_v);
        acc_count++;
        if (mon_x == COLUMNS - 1) begin
          mon_x = 0;
          if (mon_y == 0) begin
            mon_y = ROWS - 1;
            if (pend.size() >= COLUMNS) load_frame();
          end else begin
            mon_y--;
          end
        end else begin
          mon_x++;
        end
      end
      stall_q = bus.pix_valid_o & ~bus.pix_ready_i;
      held    = {bus.pix_valid_o, bus.pixel_o, bus.line_start_o, bus.frame_start_o};
    end
  end

  initial begin
    bus.pix_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_col(input logic [6:0] b, input logic [6:0] t);
    bus.start_i = 1'b1;
    bus.bar_i   = b;
    bus.top_i   = t;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    if (cur_cols.size() < COLUMNS) cur_cols.push_back({t, b});
  endtask

  // A column strobed together with NewFrame is discarded.
  task automatic send_nf(input bit with_start);
    bus.new_frame_i = 1'b1;
    bus.start_i     = with_start;
    bus.bar_i       = 7'($urandom_range(0, 127));
    bus.top_i       = 7'($urandom_range(0, 127));
    @(posedge clk);
    #1;
    bus.new_frame_i = 1'b0;
    bus.start_i     = 1'b0;
    if (cur_cols.size() == COLUMNS)
      foreach (cur_cols[i]) pend.push_back(cur_cols[i]);
    cur_cols.delete();
  endtask

  task automatic send_frame(input int ncols, input int kind, input bit nf_start, input bit do_nf);
    for (int x = 0; x < ncols; x++) begin
      logic [6:0] b;
      logic [6:0] t;
      b = 7'($urandom_range(0, 127));
      t = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(1, ROWS + 2));
      if (kind == 0) begin
        b = 7'((x * 7) % 128);
        t = 7'd0;
      end else if (kind == 1) begin
        case (x)
          5: begin t = 7'd9;            b = 7'd13;  end
          6: begin t = 7'd0;            b = 7'd0;   end
          7: begin t = 7'd0;            b = 7'd127; end
          8: begin t = 7'(ROWS - 1);    b = 7'd0;   end
          default: ;
        endcase
      end
      send_col(b, t);
    end
    if (do_nf) send_nf(nf_start);
  endtask

  task automatic wait_shown(input bit chk_lat);
    int n;
    n = 0;
    while (pend.size() != 0 && n < 4 * FRAME + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("swap_done", pend.size(), 0);
    if (chk_lat) check("swap_latency_ok", int'(n <= FRAME + 3), 1);
  endtask

  initial begin
    int ok;
    int acc0;
    int n;
    rst             = 1'b1;
    bus.new_frame_i = 1'b0;
    bus.start_i     = 1'b0;
    bus.bar_i       = 7'd0;
    bus.top_i       = 7'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", int'(bus.pix_valid_o), 0);
    check("reset_pixel", int'(bus.pixel_o), 0);
    check("reset_line_start", int'(bus.line_start_o), 0);
    check("reset_frame_start", int'(bus.frame_start_o), 0);
    repeat (20) @(negedge clk);
    check("idle_no_frame", int'(bus.pix_valid_o), 0);
    @(posedge clk);
    #1;

    // First full frame: staircase bars, no markers
    send_frame(COLUMNS, 0, 1'b0, 1'b1);
    ok = 0;
    for (int k = 0; k < 4 && ok == 0; k++) begin
      @(negedge clk);
      if (bus.pix_valid_o && bus.frame_start_o) ok = 1;
    end
    check("first_frame_start", ok, 1);
    @(posedge clk);
    #1;
    wait_shown(1'b1);

    // New frame completed mid-scan, with marker/bar corner columns
    repeat (FRAME / 2) @(posedge clk);
    #1;
    send_frame(COLUMNS, 1, 1'b0, 1'b1);
    wait_shown(1'b1);

    acc0 = acc_count;
    repeat (2 * FRAME) @(posedge clk);
    #1;
    check("throughput", acc_count - acc0, 2 * FRAME);

    // Short frame must not swap; old image keeps scanning
    send_frame(COLUMNS - 9, 2, 1'b0, 1'b1);
    repeat (2 * FRAME) @(posedge clk);
    #1;

    // Overflow: extra columns dropped
    send_frame(COLUMNS + 6, 2, 1'b0, 1'b1);
    wait_shown(1'b1);

    // Partial frame closed by NewFrame carrying a strobe, then a real frame
    send_frame(10, 2, 1'b1, 1'b1);
    send_frame(COLUMNS, 2, 1'b0, 1'b1);
    wait_shown(1'b1);

    // Random backpressure
    rdy_rand = 1'b1;
    send_frame(COLUMNS, 2, 1'b0, 1'b1);
    wait_shown(1'b0);
    repeat (2 * FRAME) @(posedge clk);
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a scan
    acc0 = acc_count;
    n = 0;
    while (acc_count < acc0 + 100 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("scan_running", int'(acc_count >= acc0 + 100), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_epoch++;
    pend.delete();
    cur_cols.delete();
    @(negedge clk);
    check("reset_midscan_valid", int'(bus.pix_valid_o), 0);
    repeat (30) @(negedge clk);
    check("idle_after_reset", int'(bus.pix_valid_o), 0);
    @(posedge clk);
    #1;
    send_frame(COLUMNS, 2, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("no_show_without_nf", int'(bus.pix_valid_o), 0);
    @(posedge clk);
    #1;
    send_nf(1'b0);
    wait_shown(1'b1);
    repeat (FRAME + 5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
